// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl
//
// Iterative sequencer for AES inverse-cipher rounds. One ciphertext block is
// accepted in IDLE, whitened with round key NR, and then pushed through the
// external combinational inverse-round datapath once per round key
// NR-1 .. 0. Round keys are fetched one at a time over key_req/key_ack. The
// plaintext is offered on out_valid/out_ready.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    ciphertext handshake (in_ready high only in IDLE)
//   in_data              ciphertext, byte 0 = bits [0:7]
//   out_valid/out_ready  plaintext handshake
//   out_data             plaintext (the state register)
//   key_req/key_idx      round-key request and index (idx 0 when idle)
//   key_ack/key_data     round key returned by the key store
//   dp_state/dp_key      inverse-round datapath operands
//   dp_final             final round: datapath skips InvMixColumns
//   dp_result            datapath output, sampled on key_ack in ROUND
//   busy                 high in every state except IDLE
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_ack,
  input  logic [0:127] key_data,
  output logic [0:127] dp_state,
  output logic [0:127] dp_key,
  output logic         dp_final,
  input  logic [0:127] dp_result,
  output logic         busy
);

  localparam logic [3:0] IDX_TOP   = 4'(NR);
  localparam logic [3:0] IDX_FIRST = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE,
    WHITEN,
    ROUND,
    DONE
  } state_t;

  state_t       state;
  logic [0:127] st;
  logic [3:0]   rnd;
  logic         idle_q;

  // All handshake outputs are registered alongside the state so that they
  // change only on the edge that changes the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      st        <= '0;
      rnd       <= '0;
      idle_q    <= 1'b1;
      out_valid <= 1'b0;
      key_req   <= 1'b0;
      key_idx   <= '0;
      dp_final  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            state    <= WHITEN;
            idle_q   <= 1'b0;
            busy     <= 1'b1;
            key_req  <= 1'b1;
            key_idx  <= IDX_TOP;
            dp_final <= 1'b0;
          end
        end
        WHITEN: begin
          if (key_ack) begin
            st       <= st ^ key_data;
            rnd      <= IDX_FIRST;
            state    <= ROUND;
            key_idx  <= IDX_FIRST;
            dp_final <= (IDX_FIRST == 4'd0);
          end
        end
        ROUND: begin
          if (key_ack) begin
            st <= dp_result;
            if (rnd == 4'd0) begin
              state     <= DONE;
              key_req   <= 1'b0;
              key_idx   <= '0;
              dp_final  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              rnd      <= rnd - 4'd1;
              key_idx  <= rnd - 4'd1;
              // next round is final when the counter is about to reach 0
              dp_final <= (rnd == 4'd1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  // Gated by rst so in_ready reads 0 while reset is held and 1 on release.
  assign in_ready = idle_q & ~rst;
  assign out_data = st;
  assign dp_state = st;
  assign dp_key   = key_data;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
module tb_aes_dec_round_ctrl;

  typedef logic [0:127] blk_t;
  typedef logic [0:255] key_t;

  typedef struct {
    logic s14;
    key_t key;
    blk_t ct;
    blk_t pt;
    int   maxd;
    int   hold;
    logic spur;
  } vec_t;

  localparam key_t K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam key_t K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam blk_t CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam blk_t PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, key_ack, sel14;
  blk_t in_data, key_data;

  logic       in_ready10, out_valid10, key_req10, dp_final10, busy10;
  logic       in_ready14, out_valid14, key_req14, dp_final14, busy14;
  logic [3:0] key_idx10, key_idx14;
  blk_t       out_data10, dp_state10, dp_key10, dp_result10;
  blk_t       out_data14, dp_state14, dp_key14, dp_result14;
  logic       iv10, iv14, ka10, ka14;

  logic       m_in_ready, m_out_valid, m_key_req, m_dp_final, m_busy;
  logic [3:0] m_key_idx;
  blk_t       m_out_data, m_dp_state;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];
  blk_t       rk    [15];
  blk_t       prev  [2];

  int checks = 0;
  int failures = 0;

  // key-store responder state
  int         maxd = 0;
  logic       spurious = 1'b0;
  int         stall_total = 0;
  int         delay = 0;
  logic       pending = 1'b0;
  logic [3:0] req_idx = '0;
  logic [4:0] idxq [$];

  always #5 clk = ~clk;

  assign iv10 = in_valid & ~sel14;
  assign iv14 = in_valid & sel14;
  assign ka10 = key_ack & ~sel14;
  assign ka14 = key_ack & sel14;

  aes_dec_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(in_ready10), .in_data(in_data),
    .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10),
    .key_req(key_req10), .key_idx(key_idx10), .key_ack(ka10), .key_data(key_data),
    .dp_state(dp_state10), .dp_key(dp_key10), .dp_final(dp_final10),
    .dp_result(dp_result10), .busy(busy10)
  );

  aes_dec_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(in_ready14), .in_data(in_data),
    .out_valid(out_valid14), .out_ready(out_ready), .out_data(out_data14),
    .key_req(key_req14), .key_idx(key_idx14), .key_ack(ka14), .key_data(key_data),
    .dp_state(dp_state14), .dp_key(dp_key14), .dp_final(dp_final14),
    .dp_result(dp_result14), .busy(busy14)
  );

  assign m_in_ready  = sel14 ? in_ready14  : in_ready10;
  assign m_out_valid = sel14 ? out_valid14 : out_valid10;
  assign m_key_req   = sel14 ? key_req14   : key_req10;
  assign m_dp_final  = sel14 ? dp_final14  : dp_final10;
  assign m_busy      = sel14 ? busy14      : busy10;
  assign m_key_idx   = sel14 ? key_idx14   : key_idx10;
  assign m_out_data  = sel14 ? out_data14  : out_data10;
  assign m_dp_state  = sel14 ? dp_state14  : dp_state10;

  // ---------------- GF(2^8) / AES helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h01;
      for (int e = 0; e < 254; e++) b = gmul(b, 8'(x));   // x^254 = x^-1
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] imc_coef(input int d);
    case (d & 3)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // External inverse-round datapath: InvShiftRows, InvSubBytes, AddRoundKey,
  // then InvMixColumns unless final.
  function automatic blk_t inv_round(input blk_t s, input blk_t k, input logic fin);
    blk_t t, m;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(4*c+r) +: 8] = isbox[s[8*(4*((c-r+4)%4)+r) +: 8]];
    t = t ^ k;
    if (fin) return t;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(imc_coef(j - i), t[8*(4*c+j) +: 8]);
        m[8*(4*c+i) +: 8] = acc;
      end
    return m;
  endfunction

  assign dp_result10 = inv_round(dp_state10, dp_key10, dp_final10);
  assign dp_result14 = inv_round(dp_state14, dp_key14, dp_final14);

  task automatic expand_key(input key_t key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference: whole inverse cipher over the current key schedule.
  function automatic blk_t ref_decrypt(input blk_t ct, input int nr);
    blk_t s;
    s = ct ^ rk[nr];
    for (int r = nr - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- key store responder ----------------
  initial begin
    key_ack  = 1'b0;
    key_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        key_ack = 1'b0;
      end else begin
        if (pending) begin
          chk("stall_req_stable", 128'(m_key_req), 128'(1'b1));
          chk("stall_idx_stable", 128'(m_key_idx), 128'(req_idx));
        end
        if (m_key_req) begin
          if (!pending) begin
            delay   = int'($urandom_range(maxd, 0));
            req_idx = m_key_idx;
          end
          if (delay == 0) begin
            key_ack  = 1'b1;
            key_data = rk[m_key_idx];
            idxq.push_back({m_dp_final, m_key_idx});
            pending  = 1'b0;
          end else begin
            delay--;
            stall_total++;
            pending  = 1'b1;
            key_ack  = 1'b0;
            key_data = {$urandom(), $urandom(), $urandom(), $urandom()};
          end
        end else begin
          pending  = 1'b0;
          key_ack  = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
          key_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_in_ready",  128'(m_in_ready),  128'(1'b0));
    chk("rst_out_valid", 128'(m_out_valid), 128'(1'b0));
    chk("rst_key_req",   128'(m_key_req),   128'(1'b0));
    chk("rst_key_idx",   128'(m_key_idx),   128'(4'd0));
    chk("rst_busy",      128'(m_busy),      128'(1'b0));
    chk("rst_dp_final",  128'(m_dp_final),  128'(1'b0));
    chk("rst_out_data",  m_out_data,        128'h0);
    chk("rst_dp_state",  m_dp_state,        128'h0);
  endtask

  // One block: offer, accept, run to completion, drain (optionally stalled).
  task automatic do_block(input logic s14, input blk_t ct, input blk_t pt, input int hold);
    int   nr, n, lat, stall0;
    logic ok;
    nr = s14 ? 14 : 10;
    @(negedge clk);
    sel14 = s14;
    out_ready = (hold == 0);
    #1;
    chk("idle_st_held", m_out_data, prev[s14]);
    in_valid = 1'b1;
    in_data  = ct;
    n = 0;
    while (!m_in_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("accept_wait", 128'(n < 50), 128'(1'b1));
    @(posedge clk);                       // acceptance edge E0
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    idxq.delete();
    stall0 = stall_total;
    chk("accept_busy",     128'(m_busy),     128'(1'b1));
    chk("accept_in_ready", 128'(m_in_ready), 128'(1'b0));
    lat = 0;
    while (!m_out_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    chk("latency", 128'(lat), 128'(nr + 1 + (stall_total - stall0)));
    chk("plaintext", m_out_data, pt);
    chk("idx_count", 128'(idxq.size()), 128'(nr + 1));
    ok = 1'b1;
    for (int i = 0; i < idxq.size() && i <= nr; i++)
      if (idxq[i] !== {(i == nr), 4'(nr - i)}) ok = 1'b0;
    chk("idx_sequence", 128'(ok), 128'(1'b1));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk("hold_out_valid", 128'(m_out_valid), 128'(1'b1));
      chk("hold_out_data",  m_out_data, pt);
      chk("hold_in_ready",  128'(m_in_ready), 128'(1'b0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", 128'(m_out_valid), 128'(1'b0));
    chk("drain_in_ready",  128'(m_in_ready),  128'(1'b1));
    chk("drain_st_held",   m_out_data, pt);
    prev[s14] = pt;
  endtask

  vec_t tbl [5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel14 = 1'b0;
    prev[0] = '0; prev[1] = '0;
    init_tables();

    tbl[0] = '{1'b0, K128, CT128, PT, 0, 0,  1'b0};
    tbl[1] = '{1'b0, K128, CT128, PT, 5, 0,  1'b0};
    tbl[2] = '{1'b0, K128, CT128, PT, 0, 20, 1'b1};
    tbl[3] = '{1'b1, K256, CT256, PT, 0, 0,  1'b0};
    tbl[4] = '{1'b1, K256, CT256, PT, 4, 2,  1'b1};

    #2;
    chk_reset_outputs();
    #10 rst = 1'b0;
    #1;
    chk("release_in_ready", 128'(m_in_ready), 128'(1'b1));

    for (int i = 0; i < 5; i++) begin
      expand_key(tbl[i].key, tbl[i].s14 ? 8 : 4, tbl[i].s14 ? 14 : 10);
      maxd     = tbl[i].maxd;
      spurious = tbl[i].spur;
      do_block(tbl[i].s14, tbl[i].ct, tbl[i].pt, tbl[i].hold);
    end

    // reset in the middle of ROUND, after the 4th key ack
    expand_key(K128, 4, 10);
    maxd = 0; spurious = 1'b0;
    @(negedge clk);
    sel14 = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = CT128;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midround_key_idx", 128'(m_key_idx), 128'(4'd6));
    chk("midround_key_req", 128'(m_key_req), 128'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs();
    #10 rst = 1'b0;
    #1;
    chk("rerelease_in_ready", 128'(m_in_ready), 128'(1'b1));
    prev[0] = '0; prev[1] = '0;
    do_block(1'b0, CT128, PT, 0);

    // randomized blocks against the reference inverse cipher
    for (int t = 0; t < 6; t++) begin
      key_t k;
      blk_t ct, pt;
      logic s;
      s  = 1'($urandom_range(1, 0));
      k  = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(k, s ? 8 : 4, s ? 14 : 10);
      pt = ref_decrypt(ct, s ? 14 : 10);
      maxd     = int'($urandom_range(5, 0));
      spurious = 1'($urandom_range(1, 0));
      do_block(s, ct, pt, int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
